rs_alu_issue: RTL and testbench
===============================

# rs_alu_issue

Reservation station feeding one `exunit_alu` instance.
- Accepts one dispatched ALU op per cycle and holds it until both source operands are available.
- Captures operands from two result-forwarding buses.
- Issues at most one ready entry per cycle.
- Purges speculative entries on branch-miss.
- Payload registers drive the execute unit's `ex_src1`, `ex_src2`, `pc`, `imm`, `dstval`, `src_a`, `src_b`, `alu_op`, `spectag`, `specbit` inputs directly, in the cycle the unit's internal busy is high.

## Interface
Parameters:
- `ENT_NUM`, default 8: number of entries, power of two, at least 2.
- `ENT_SEL`, default 3: log2(`ENT_NUM`).

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `dp_we`  in  1  dispatch write strobe
- `dp_src1`, `dp_src2`  in  `DATA_LEN`  operand value or producer RRF tag (low `RRF_SEL` bits)
- `dp_vld1`, `dp_vld2`  in  1  operand holds a value (1) or a tag (0)
- `dp_pc`  in  `ADDR_LEN`
- `dp_imm`  in  `DATA_LEN`
- `dp_rrftag`  in  `RRF_SEL`  destination tag
- `dp_dstval`  in  1
- `dp_src_a`  in  `SRC_A_SEL_WIDTH`
- `dp_src_b`  in  `SRC_B_SEL_WIDTH`
- `dp_alu_op`  in  `ALU_OP_WIDTH`
- `dp_spectag`  in  `SPECTAG_LEN`
- `dp_specbit`  in  1
- `wk0_we`, `wk1_we`  in  1  forwarding-bus valid
- `wk0_tag`, `wk1_tag`  in  `RRF_SEL`
- `wk0_data`, `wk1_data`  in  `DATA_LEN`
- `prmiss`, `prsuccess`  in  1
- `spectagfix`  in  `SPECTAG_LEN`
- `full`  out  1  no free entry
- `free_cnt`  out  `ENT_SEL+1`
- `issue`  out  1  combinational select strobe; wired to exunit `issue`
- `ex_*`  out  payload of the issued entry, registered: `ex_src1`, `ex_src2`, `ex_pc`, `ex_imm`, `ex_rrftag`, `ex_dstval`, `ex_src_a`, `ex_src_b`, `ex_alu_op`, `ex_spectag`, `ex_specbit`

## Operation
Entry state: `valid`, `vld1`, `vld2`, payload, `specbit`, `spectag`.

Dispatch:
- `dp_we` writes the lowest-index free entry.
- `dp_we` while `full` is illegal; the bench asserts on it.

Wakeup:
- Every valid entry with `vldN=0` compares its operand tag against each bus with `wkX_we=1`.
- On a match it stores `wkX_data` and sets `vldN`. `wk0` has priority when both buses match.
- Dispatch bypass: if a `dp_*` operand tag matches a same-cycle wakeup, the entry is written with the value and `vld=1`.

Ready and issue:
- An entry is ready when `valid & vld1 & vld2`.
- The select picks one ready entry: lowest index, or oldest (see Configuration).
- `issue = |ready & ~kill_sel`, where `kill_sel` means the selected entry is being killed this cycle.
- On issue, the entry's `valid` clears at the clock edge and `ex_*` load from it.

Speculation:
- Kill condition: `prmiss & specbit & |(spectag & spectagfix)`.
- Killed entries have `valid` cleared.
- On `prsuccess`, entries with `|(spectag & spectagfix)` have `specbit` cleared.
- `prmiss` and `prsuccess` together is illegal.

Counters and outputs:
- `free_cnt` = `ENT_NUM` − popcount(`valid`), registered.
- `full = (free_cnt==0)`.
- `ex_*` hold their last value when `issue=0`.

## Timing
- Reset: all `valid=0`, `issue=0`, `free_cnt=ENT_NUM`, `full=0`, every `ex_*` = 0.
- Dispatch at edge N. The entry is eligible for select in cycle N+1 if both operands are valid, including via bypass.
- Wakeup at edge N. The entry is eligible in cycle N+1; there is no same-cycle wakeup-to-issue.
- `issue` high in cycle N:
  - `ex_*` valid in cycle N+1, which is the exunit's busy cycle.
  - The entry is free from cycle N+1 and may be redispatched in N+1.
- Dispatch into a slot freed by issue in the same cycle is not possible; `full` is computed from the registered `valid`.
- Kill and issue on the same entry in the same cycle: kill wins, `issue=0`, `ex_*` unchanged.
- Kill and dispatch of a speculative op in the same cycle: dispatch is accepted. The upstream stage suppresses killed dispatches itself.
- `free_cnt` updates one cycle after each dispatch, issue, or kill, and reflects all events of that edge simultaneously.

## Configuration
`RS_ALU_OLDEST_FIRST_EN`:
- Defined: an `ENT_NUM`×`ENT_NUM` age matrix is maintained.
  - On dispatch, the new row is cleared and its column set in all other rows.
  - The selected entry is the ready entry with no older ready entry.
- Undefined: no age matrix is built; the select is a pure lowest-index priority encoder.

## Structure
- `ENT_NUM` and `ENT_SEL` defaults are added to `constants.vh` as `RS_ALU_ENT_NUM` and `RS_ALU_ENT_SEL`.
- Existing `DATA_LEN`, `RRF_SEL`, `SPECTAG_LEN` and the `alu_ops.vh` widths are reused.
- One sub-module, `rs_alu_select`:
  - inputs: ready vector, optional age matrix;
  - outputs: one-hot grant and index;
  - also reused for the free-slot search with the vector inverted.

## Test plan
- Reset, then dispatch `alu_op=ADD`, src1=5/vld, src2=7/vld at cycle 0 → `issue=1` in cycle 1; `ex_src1=5`, `ex_src2=7` in cycle 2; `free_cnt` 8→7→8.
- Dispatch with src2 tag=12 not valid; `wk1_we`, tag 12, data `0xDEAD` in cycle 3 → `issue` in cycle 4, `ex_src2=0xDEAD`.
- Dispatch with src1 tag 9 while `wk0_we`, tag 9, data 0x33 in the same cycle → entry written valid, `issue` next cycle with `ex_src1=0x33`.
- Fill 8 entries with a tag pending → `full=1`, `free_cnt=0`. Wake one → one issue, then `full=0`.
- Entries with `spectag` 00010 and 00100, both specbit; `prmiss`, `spectagfix=00010` → the first is removed and never issues, the second issues normally.
- With `RS_ALU_OLDEST_FIRST_EN`:
  - Dispatch A→entry 1, then free entry 0, dispatch B→entry 0.
  - Wake both in the same cycle → A issues first.
  - Without the macro → B issues first.

Source files
------------

// File: rtl/rs_alu_issue_pkg.sv
// Shared types, widths and operand-forwarding helper for the ALU
// reservation station.
package rs_alu_issue_pkg;

  localparam int DATA_LEN        = 32;
  localparam int ADDR_LEN        = 32;
  localparam int RRF_SEL         = 6;
  localparam int SPECTAG_LEN     = 5;
  localparam int SRC_A_SEL_WIDTH = 2;
  localparam int SRC_B_SEL_WIDTH = 2;
  localparam int ALU_OP_WIDTH    = 4;

  localparam int RS_ALU_ENT_NUM  = 8;
  localparam int RS_ALU_ENT_SEL  = 3;

  typedef logic [DATA_LEN-1:0]    data_t;
  typedef logic [ADDR_LEN-1:0]    addr_t;
  typedef logic [RRF_SEL-1:0]     tag_t;
  typedef logic [SPECTAG_LEN-1:0] spectag_t;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SEQ  = 4'd8,
    ALU_SNE  = 4'd9,
    ALU_SUB  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_SLT  = 4'd12,
    ALU_SGE  = 4'd13,
    ALU_SLTU = 4'd14,
    ALU_SGEU = 4'd15
  } alu_op_t;

  typedef struct packed {
    logic  vld;
    data_t val;
  } opnd_t;

  typedef struct packed {
    addr_t                      pc;
    data_t                      imm;
    tag_t                       rrftag;
    logic                       dstval;
    logic [SRC_A_SEL_WIDTH-1:0] src_a;
    logic [SRC_B_SEL_WIDTH-1:0] src_b;
    alu_op_t                    alu_op;
    spectag_t                   spectag;
    logic                       specbit;
  } rs_ctl_t;

  typedef struct packed {
    logic    valid;
    opnd_t   op1;
    opnd_t   op2;
    rs_ctl_t ctl;
  } rs_ent_t;

  // wk0 takes priority when both buses carry the waited-for tag
  function automatic opnd_t fwd(
    opnd_t o,
    logic  w0, tag_t t0, data_t d0,
    logic  w1, tag_t t1, data_t d1
  );
    opnd_t r;
    r = o;
    if (!o.vld) begin
      if (w0 && t0 == o.val[RRF_SEL-1:0]) begin
        r.vld = 1'b1;
        r.val = d0;
      end else if (w1 && t1 == o.val[RRF_SEL-1:0]) begin
        r.vld = 1'b1;
        r.val = d1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_alu_issue_if.sv
// Dispatch, wakeup, speculation and execute-payload bundle of the
// ALU reservation station.
interface rs_alu_issue_if
  import rs_alu_issue_pkg::*;
#(
  parameter int ENT_SEL = RS_ALU_ENT_SEL
)();

  logic                       dp_we;
  data_t                      dp_src1;
  data_t                      dp_src2;
  logic                       dp_vld1;
  logic                       dp_vld2;
  addr_t                      dp_pc;
  data_t                      dp_imm;
  tag_t                       dp_rrftag;
  logic                       dp_dstval;
  logic [SRC_A_SEL_WIDTH-1:0] dp_src_a;
  logic [SRC_B_SEL_WIDTH-1:0] dp_src_b;
  logic [ALU_OP_WIDTH-1:0]    dp_alu_op;
  spectag_t                   dp_spectag;
  logic                       dp_specbit;

  logic                       wk0_we;
  tag_t                       wk0_tag;
  data_t                      wk0_data;
  logic                       wk1_we;
  tag_t                       wk1_tag;
  data_t                      wk1_data;

  logic                       prmiss;
  logic                       prsuccess;
  spectag_t                   spectagfix;

  logic                       full;
  logic [ENT_SEL:0]           free_cnt;
  logic                       issue;

  data_t                      ex_src1;
  data_t                      ex_src2;
  addr_t                      ex_pc;
  data_t                      ex_imm;
  tag_t                       ex_rrftag;
  logic                       ex_dstval;
  logic [SRC_A_SEL_WIDTH-1:0] ex_src_a;
  logic [SRC_B_SEL_WIDTH-1:0] ex_src_b;
  logic [ALU_OP_WIDTH-1:0]    ex_alu_op;
  spectag_t                   ex_spectag;
  logic                       ex_specbit;

  modport master (
    output dp_we, dp_src1, dp_src2, dp_vld1, dp_vld2,
    output dp_pc, dp_imm, dp_rrftag, dp_dstval,
    output dp_src_a, dp_src_b, dp_alu_op,
    output dp_spectag, dp_specbit,
    output wk0_we, wk0_tag, wk0_data,
    output wk1_we, wk1_tag, wk1_data,
    output prmiss, prsuccess, spectagfix,
    input  full, free_cnt, issue,
    input  ex_src1, ex_src2, ex_pc, ex_imm,
    input  ex_rrftag, ex_dstval, ex_src_a, ex_src_b,
    input  ex_alu_op, ex_spectag, ex_specbit
  );

  modport slave (
    input  dp_we, dp_src1, dp_src2, dp_vld1, dp_vld2,
    input  dp_pc, dp_imm, dp_rrftag, dp_dstval,
    input  dp_src_a, dp_src_b, dp_alu_op,
    input  dp_spectag, dp_specbit,
    input  wk0_we, wk0_tag, wk0_data,
    input  wk1_we, wk1_tag, wk1_data,
    input  prmiss, prsuccess, spectagfix,
    output full, free_cnt, issue,
    output ex_src1, ex_src2, ex_pc, ex_imm,
    output ex_rrftag, ex_dstval, ex_src_a, ex_src_b,
    output ex_alu_op, ex_spectag, ex_specbit
  );

endinterface

// File: rtl/rs_alu_issue_select.sv
// One-hot grant over a request vector: lowest index, or the oldest
// request when AGE_EN and age[i*N+j] means entry i is older than j.
module rs_alu_select #(
  parameter int N      = 8,
  parameter int SEL    = 3,
  parameter bit AGE_EN = 1'b0
)(
  input  logic [N-1:0]   req,
  input  logic [N*N-1:0] age,
  output logic [N-1:0]   grant,
  output logic [SEL-1:0] idx,
  output logic           any
);

  if (AGE_EN) begin : g_age
    logic [N-1:0] blocked;

    always_comb begin
      blocked = '0;
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && age[i*N+j]) blocked[j] = 1'b1;
        end
      end
    end

    assign grant = req & ~blocked;
  end else begin : g_pri
    logic unused_age;

    assign unused_age = ^age;

    always_comb begin
      grant = '0;
      for (int j = N - 1; j >= 0; j--) begin
        if (req[j]) grant = N'(1) << j;
      end
    end
  end

  always_comb begin
    idx = '0;
    for (int j = 0; j < N; j++) begin
      if (grant[j]) idx = idx | SEL'(j);
    end
  end

  assign any = |req;

endmodule

// File: rtl/rs_alu_issue.sv
// ALU reservation station: wakeup, select, speculative purge.
// RS_ALU_OLDEST_FIRST_EN selects oldest-ready instead of lowest index.
module rs_alu_issue
  import rs_alu_issue_pkg::*;
#(
  parameter int ENT_NUM = RS_ALU_ENT_NUM,
  parameter int ENT_SEL = RS_ALU_ENT_SEL
)(
  input logic           clk,
  input logic           reset,
  rs_alu_issue_if.slave io
);

  localparam int CNT_W = ENT_SEL + 1;

  rs_ent_t              ent     [ENT_NUM];
  rs_ent_t              ent_nxt [ENT_NUM];
  rs_ent_t              dp_ent;

  logic [ENT_NUM-1:0]   valid;
  logic [ENT_NUM-1:0]   ready;
  logic [ENT_NUM-1:0]   kill;
  logic [ENT_NUM-1:0]   sel_grant;
  logic [ENT_NUM-1:0]   free_grant;
  logic [ENT_SEL-1:0]   sel_idx;
  logic [ENT_SEL-1:0]   unused_free_idx;
  logic                 sel_any;
  logic                 free_any;
  logic                 kill_sel;
  logic                 issue;
  logic                 disp;

  logic [CNT_W-1:0]     free_q;
  logic [CNT_W-1:0]     free_nxt;

  data_t                ex_src1;
  data_t                ex_src2;
  rs_ctl_t              ex_ctl;

  logic [ENT_NUM*ENT_NUM-1:0] age_flat;

  always_comb begin
    valid = '0;
    ready = '0;
    kill  = '0;
    for (int i = 0; i < ENT_NUM; i++) begin
      valid[i] = ent[i].valid;
      ready[i] = ent[i].valid
               & ent[i].op1.vld
               & ent[i].op2.vld;
      kill[i]  = io.prmiss
               & ent[i].valid
               & ent[i].ctl.specbit
               & (|(ent[i].ctl.spectag & io.spectagfix));
    end
  end

  assign disp = io.dp_we & free_any;

`ifdef RS_ALU_OLDEST_FIRST_EN
  localparam bit AGE_EN = 1'b1;

  logic [ENT_NUM-1:0][ENT_NUM-1:0] age;
  logic [ENT_NUM-1:0][ENT_NUM-1:0] age_nxt;

  // new entry: older than nobody, every other entry older than it
  always_comb begin
    age_nxt = age;
    if (disp) begin
      for (int r = 0; r < ENT_NUM; r++) begin
        for (int c = 0; c < ENT_NUM; c++) begin
          if (free_grant[r])      age_nxt[r][c] = 1'b0;
          else if (free_grant[c]) age_nxt[r][c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) age <= '0;
    else       age <= age_nxt;
  end

  assign age_flat = age;
`else
  localparam bit AGE_EN = 1'b0;

  assign age_flat = '0;
`endif

  rs_alu_select #(
    .N      (ENT_NUM),
    .SEL    (ENT_SEL),
    .AGE_EN (AGE_EN)
  ) u_sel (
    .req   (ready),
    .age   (age_flat),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  rs_alu_select #(
    .N      (ENT_NUM),
    .SEL    (ENT_SEL),
    .AGE_EN (1'b0)
  ) u_free (
    .req   (~valid),
    .age   ('0),
    .grant (free_grant),
    .idx   (unused_free_idx),
    .any   (free_any)
  );

  assign kill_sel = |(sel_grant & kill);
  assign issue    = sel_any & ~kill_sel;

  // operands captured from a same-cycle wakeup go in already valid
  always_comb begin
    opnd_t o1;
    opnd_t o2;
    o1.vld = io.dp_vld1;
    o1.val = io.dp_src1;
    o2.vld = io.dp_vld2;
    o2.val = io.dp_src2;
    dp_ent.valid       = 1'b1;
    dp_ent.op1         = fwd(o1,
      io.wk0_we, io.wk0_tag, io.wk0_data,
      io.wk1_we, io.wk1_tag, io.wk1_data);
    dp_ent.op2         = fwd(o2,
      io.wk0_we, io.wk0_tag, io.wk0_data,
      io.wk1_we, io.wk1_tag, io.wk1_data);
    dp_ent.ctl.pc      = io.dp_pc;
    dp_ent.ctl.imm     = io.dp_imm;
    dp_ent.ctl.rrftag  = io.dp_rrftag;
    dp_ent.ctl.dstval  = io.dp_dstval;
    dp_ent.ctl.src_a   = io.dp_src_a;
    dp_ent.ctl.src_b   = io.dp_src_b;
    dp_ent.ctl.alu_op  = alu_op_t'(io.dp_alu_op);
    dp_ent.ctl.spectag = io.dp_spectag;
    dp_ent.ctl.specbit = io.dp_specbit;
  end

  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].valid) begin
        ent_nxt[i].op1 = fwd(ent[i].op1,
          io.wk0_we, io.wk0_tag, io.wk0_data,
          io.wk1_we, io.wk1_tag, io.wk1_data);
        ent_nxt[i].op2 = fwd(ent[i].op2,
          io.wk0_we, io.wk0_tag, io.wk0_data,
          io.wk1_we, io.wk1_tag, io.wk1_data);
      end
      if (io.prsuccess &&
          |(ent[i].ctl.spectag & io.spectagfix))
        ent_nxt[i].ctl.specbit = 1'b0;
      if (kill[i] || (issue && sel_grant[i]))
        ent_nxt[i].valid = 1'b0;
      if (disp && free_grant[i])
        ent_nxt[i] = dp_ent;
    end
  end

  always_comb begin
    free_nxt = CNT_W'(ENT_NUM);
    for (int i = 0; i < ENT_NUM; i++) begin
      if (ent_nxt[i].valid) free_nxt = free_nxt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENT_NUM; i++) ent[i] <= '0;
      free_q  <= CNT_W'(ENT_NUM);
      ex_src1 <= '0;
      ex_src2 <= '0;
      ex_ctl  <= '0;
    end else begin
      for (int i = 0; i < ENT_NUM; i++) ent[i] <= ent_nxt[i];
      free_q <= free_nxt;
      if (issue) begin
        ex_src1 <= ent[sel_idx].op1.val;
        ex_src2 <= ent[sel_idx].op2.val;
        ex_ctl  <= ent[sel_idx].ctl;
      end
    end
  end

  assign io.full       = (free_q == '0);
  assign io.free_cnt   = free_q;
  assign io.issue      = issue;
  assign io.ex_src1    = ex_src1;
  assign io.ex_src2    = ex_src2;
  assign io.ex_pc      = ex_ctl.pc;
  assign io.ex_imm     = ex_ctl.imm;
  assign io.ex_rrftag  = ex_ctl.rrftag;
  assign io.ex_dstval  = ex_ctl.dstval;
  assign io.ex_src_a   = ex_ctl.src_a;
  assign io.ex_src_b   = ex_ctl.src_b;
  assign io.ex_alu_op  = ex_ctl.alu_op;
  assign io.ex_spectag = ex_ctl.spectag;
  assign io.ex_specbit = ex_ctl.specbit;

endmodule

// File: tb/tb_rs_alu_issue.sv
// Bench for rs_alu_issue: sequence-number model checked every cycle
// plus directed scenarios with literal expectations.
module tb_rs_alu_issue;
  import rs_alu_issue_pkg::*;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  rs_alu_issue_if #(.ENT_SEL(3)) io();

  rs_alu_issue #(
    .ENT_NUM (N),
    .ENT_SEL (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string name, logic [255:0] act,
                       logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h want %0h",
                  name, $time, act, exp);
  endtask

  typedef struct {
    bit          v;
    bit          v1;
    bit          v2;
    logic [31:0] s1;
    logic [31:0] s2;
    int          seq;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  tag;
    logic        dstval;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [3:0]  op;
    logic [4:0]  st;
    logic        spb;
  } m_ent_t;

  m_ent_t       m [N];
  logic [255:0] m_ex;
  int           m_free;
  bit           m_init  = 0;
  int           seq_ctr = 0;

  function automatic logic [255:0] pack_ex(m_ent_t e);
    return {e.s1, e.s2, e.pc, e.imm, e.tag, e.dstval,
            e.sa, e.sb, e.op, e.st, e.spb};
  endfunction

  function automatic logic [255:0] dut_ex();
    return {io.ex_src1, io.ex_src2, io.ex_pc, io.ex_imm,
            io.ex_rrftag, io.ex_dstval, io.ex_src_a,
            io.ex_src_b, io.ex_alu_op, io.ex_spectag,
            io.ex_specbit};
  endfunction

  function automatic logic [32:0] res(bit v, logic [31:0] s);
    if (!v && io.wk0_we && io.wk0_tag == s[5:0])
      return {1'b1, io.wk0_data};
    if (!v && io.wk1_we && io.wk1_tag == s[5:0])
      return {1'b1, io.wk1_data};
    return {v, s};
  endfunction

  function automatic bit mkill(int i);
    return io.prmiss && m[i].v && m[i].spb
        && (|(m[i].st & io.spectagfix));
  endfunction

  // negedge: compare against model, then advance it to the next edge
  always @(negedge clk) begin
    int          sel;
    int          slot;
    int          cnt;
    bit          exp_issue;
    bit          k [N];
    logic [32:0] r;
    sel = -1;
    for (int i = 0; i < N; i++) begin
      if (m[i].v && m[i].v1 && m[i].v2) begin
`ifdef RS_ALU_OLDEST_FIRST_EN
        if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    exp_issue = (sel >= 0) && !mkill(sel);
    if (m_init && !reset) begin
      check("cyc issue", io.issue, exp_issue);
      check("cyc free_cnt", io.free_cnt, m_free);
      check("cyc full", io.full, m_free == 0);
      check("cyc ex", dut_ex(), m_ex);
      assert (!(io.dp_we && io.full))
        else $error("FAIL dispatch while full");
    end
    if (reset) begin
      for (int i = 0; i < N; i++) m[i].v = 0;
      m_ex   = '0;
      m_free = N;
      m_init = 1;
    end else begin
      slot = -1;
      for (int i = 0; i < N; i++)
        if (!m[i].v && slot < 0) slot = i;
      for (int i = 0; i < N; i++) k[i] = mkill(i);
      if (exp_issue) m_ex = pack_ex(m[sel]);
      for (int i = 0; i < N; i++) begin
        if (m[i].v) begin
          r = res(m[i].v1, m[i].s1);
          m[i].v1 = r[32];
          m[i].s1 = r[31:0];
          r = res(m[i].v2, m[i].s2);
          m[i].v2 = r[32];
          m[i].s2 = r[31:0];
        end
        if (io.prsuccess && |(m[i].st & io.spectagfix))
          m[i].spb = 0;
        if (k[i]) m[i].v = 0;
      end
      if (exp_issue) m[sel].v = 0;
      if (io.dp_we && slot >= 0) begin
        m[slot].v = 1;
        r = res(io.dp_vld1, io.dp_src1);
        m[slot].v1 = r[32];
        m[slot].s1 = r[31:0];
        r = res(io.dp_vld2, io.dp_src2);
        m[slot].v2 = r[32];
        m[slot].s2 = r[31:0];
        m[slot].seq    = seq_ctr++;
        m[slot].pc     = io.dp_pc;
        m[slot].imm    = io.dp_imm;
        m[slot].tag    = io.dp_rrftag;
        m[slot].dstval = io.dp_dstval;
        m[slot].sa     = io.dp_src_a;
        m[slot].sb     = io.dp_src_b;
        m[slot].op     = io.dp_alu_op;
        m[slot].st     = io.dp_spectag;
        m[slot].spb    = io.dp_specbit;
      end
      cnt = 0;
      for (int i = 0; i < N; i++) if (m[i].v) cnt++;
      m_free = N - cnt;
    end
  end

  task automatic idle();
    io.dp_we      = 0;
    io.dp_src1    = '0;
    io.dp_src2    = '0;
    io.dp_vld1    = 0;
    io.dp_vld2    = 0;
    io.dp_pc      = '0;
    io.dp_imm     = '0;
    io.dp_rrftag  = '0;
    io.dp_dstval  = 0;
    io.dp_src_a   = '0;
    io.dp_src_b   = '0;
    io.dp_alu_op  = '0;
    io.dp_spectag = '0;
    io.dp_specbit = 0;
    io.wk0_we     = 0;
    io.wk0_tag    = '0;
    io.wk0_data   = '0;
    io.wk1_we     = 0;
    io.wk1_tag    = '0;
    io.wk1_data   = '0;
    io.prmiss     = 0;
    io.prsuccess  = 0;
    io.spectagfix = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic disp(logic [31:0] s1, bit v1,
                      logic [31:0] s2, bit v2,
                      logic [4:0] st, bit spb,
                      logic [31:0] imm);
    io.dp_we      = 1;
    io.dp_src1    = s1;
    io.dp_vld1    = v1;
    io.dp_src2    = s2;
    io.dp_vld2    = v2;
    io.dp_pc      = 32'h1000 + imm;
    io.dp_imm     = imm;
    io.dp_rrftag  = imm[5:0];
    io.dp_dstval  = 1;
    io.dp_src_a   = 2'd1;
    io.dp_src_b   = 2'd2;
    io.dp_alu_op  = ALU_ADD;
    io.dp_spectag = st;
    io.dp_specbit = spb;
  endtask

  task automatic wake(int bus, logic [5:0] tag,
                      logic [31:0] data);
    if (bus == 0) begin
      io.wk0_we   = 1;
      io.wk0_tag  = tag;
      io.wk0_data = data;
    end else begin
      io.wk1_we   = 1;
      io.wk1_tag  = tag;
      io.wk1_data = data;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit done;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    mid();
    check("rst issue", io.issue, 0);
    check("rst free_cnt", io.free_cnt, 8);
    check("rst full", io.full, 0);
    check("rst ex", dut_ex(), 0);

    // ready-at-dispatch ADD 5,7
    cyc();
    disp(5, 1, 7, 1, 5'b0, 0, 32'h1);
    cyc();
    idle();
    mid();
    check("t1 issue", io.issue, 1);
    check("t1 free7", io.free_cnt, 7);
    cyc();
    mid();
    check("t1 ex_src1", io.ex_src1, 5);
    check("t1 ex_src2", io.ex_src2, 7);
    check("t1 free8", io.free_cnt, 8);

    // src2 waits on tag 12, woken by wk1
    cyc();
    disp(1, 1, 12, 0, 5'b0, 0, 32'h2);
    cyc();
    idle();
    mid();
    check("t2 wait", io.issue, 0);
    cyc();
    wake(1, 6'd12, 32'hDEAD);
    mid();
    check("t2 no same-cycle", io.issue, 0);
    cyc();
    idle();
    mid();
    check("t2 issue", io.issue, 1);
    cyc();
    mid();
    check("t2 ex_src2", io.ex_src2, 32'hDEAD);

    // dispatch bypass from wk0
    cyc();
    disp(9, 0, 2, 1, 5'b0, 0, 32'h3);
    wake(0, 6'd9, 32'h33);
    cyc();
    idle();
    mid();
    check("t3 issue", io.issue, 1);
    cyc();
    mid();
    check("t3 ex_src1", io.ex_src1, 32'h33);

    // fill all entries, each waiting on its own tag
    for (int i = 0; i < N; i++) begin
      cyc();
      disp(20 + i, 0, i, 1, 5'b0, 0, 32'h40 + i);
    end
    cyc();
    idle();
    mid();
    check("t4 full", io.full, 1);
    check("t4 free0", io.free_cnt, 0);
    cyc();
    wake(0, 6'd23, 32'h77);
    mid();
    check("t4 wake no issue", io.issue, 0);
    cyc();
    idle();
    mid();
    check("t4 issue", io.issue, 1);
    cyc();
    mid();
    check("t4 not full", io.full, 0);
    check("t4 free1", io.free_cnt, 1);
    check("t4 ex_src1", io.ex_src1, 32'h77);
    check("t4 ex_imm", io.ex_imm, 32'h43);
    cyc();
    wake(0, 6'd20, 32'h120);
    wake(1, 6'd21, 32'h121);
    cyc();
    idle();
    wake(0, 6'd22, 32'h122);
    wake(1, 6'd24, 32'h124);
    cyc();
    idle();
    wake(0, 6'd25, 32'h125);
    wake(1, 6'd26, 32'h126);
    cyc();
    idle();
    wake(0, 6'd27, 32'h127);
    cyc();
    idle();
    done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      mid();
      if (io.free_cnt == 8) done = 1;
      else cyc();
    end
    check("t4 drain", done, 1);

    // branch miss kills spectag 00010, 00100 survives
    cyc();
    disp(30, 0, 1, 1, 5'b00010, 1, 32'h50);
    cyc();
    disp(31, 0, 2, 1, 5'b00100, 1, 32'h51);
    cyc();
    idle();
    io.prmiss     = 1;
    io.spectagfix = 5'b00010;
    mid();
    check("t5 kill cyc", io.issue, 0);
    check("t5 free6", io.free_cnt, 6);
    cyc();
    idle();
    mid();
    check("t5 free7", io.free_cnt, 7);
    cyc();
    wake(0, 6'd30, 32'hA0);
    wake(1, 6'd31, 32'hB1);
    cyc();
    idle();
    mid();
    check("t5 issue", io.issue, 1);
    cyc();
    mid();
    check("t5 ex_src1", io.ex_src1, 32'hB1);
    check("t5 ex_spectag", io.ex_spectag, 5'b00100);
    check("t5 killed silent", io.issue, 0);
    check("t5 free8", io.free_cnt, 8);

    // kill beats issue on the same entry
    cyc();
    disp(3, 1, 4, 1, 5'b00010, 1, 32'h60);
    cyc();
    idle();
    io.prmiss     = 1;
    io.spectagfix = 5'b00010;
    mid();
    check("t5k issue", io.issue, 0);
    cyc();
    idle();
    mid();
    check("t5k free8", io.free_cnt, 8);
    check("t5k ex held", io.ex_imm, 32'h51);

    // prsuccess clears specbit, later miss does not kill
    cyc();
    disp(35, 0, 1, 1, 5'b01000, 1, 32'h70);
    cyc();
    idle();
    io.prsuccess  = 1;
    io.spectagfix = 5'b01000;
    cyc();
    idle();
    io.prmiss     = 1;
    io.spectagfix = 5'b01000;
    cyc();
    idle();
    wake(0, 6'd35, 32'h99);
    mid();
    check("t5s survives", io.free_cnt, 7);
    cyc();
    idle();
    mid();
    check("t5s issue", io.issue, 1);
    cyc();
    mid();
    check("t5s ex_src1", io.ex_src1, 32'h99);
    check("t5s ex_specbit", io.ex_specbit, 0);

    // A in entry 1, then B into freed entry 0
    cyc();
    disp(40, 0, 1, 1, 5'b0, 0, 32'h80);
    cyc();
    disp(41, 0, 2, 1, 5'b0, 0, 32'h81);
    cyc();
    idle();
    wake(0, 6'd40, 32'h1);
    cyc();
    idle();
    mid();
    check("t6 x issue", io.issue, 1);
    cyc();
    disp(42, 0, 3, 1, 5'b0, 0, 32'h82);
    cyc();
    idle();
    wake(0, 6'd41, 32'hAA);
    wake(1, 6'd42, 32'hBB);
    cyc();
    idle();
    mid();
    check("t6 first issue", io.issue, 1);
    cyc();
    mid();
`ifdef RS_ALU_OLDEST_FIRST_EN
    check("t6 first ex_imm", io.ex_imm, 32'h81);
`else
    check("t6 first ex_imm", io.ex_imm, 32'h82);
`endif
    check("t6 second issue", io.issue, 1);
    cyc();
    mid();
`ifdef RS_ALU_OLDEST_FIRST_EN
    check("t6 second ex_imm", io.ex_imm, 32'h82);
`else
    check("t6 second ex_imm", io.ex_imm, 32'h81);
`endif
    check("t6 free8", io.free_cnt, 8);

    cyc();
    mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
